obi_stream_wdma: RTL and testbench

Stream-to-memory write DMA for the user domain: accepts a (byte address, byte length) command plus a 32-bit word stream (valid/ready) and writes the words to consecutive word addresses through one OBI manager port. It is the write-direction counterpart of the OBI read DMAs that turn memory into a word stream. A user-domain OBI subordinate drives its command and stream inputs, and its manager port connects to one croc subordinate slot.

---
 rtl/user_pkg.sv | 49 ++++
 rtl/obi_stream_wdma_fifo.sv | 56 +++++
 rtl/obi_stream_wdma.sv | 160 ++++++++++++++++
 tb/tb_obi_stream_wdma.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_pkg.sv
// Shared types for the user domain: OBI manager channel structs, the write-DMA state enum
// and the byte-length to final-word byte-enable mapping.
package user_pkg;

    typedef enum logic [1:0] {
        WDMA_IDLE  = 2'd0,
        WDMA_RUN   = 2'd1,
        WDMA_DRAIN = 2'd2
    } wdma_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        aid;
    } mgr_obi_a_chan_t;

    typedef struct packed {
        mgr_obi_a_chan_t a;
        logic            req;
        logic            rready;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        rid;
        logic        err;
    } mgr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        mgr_obi_r_chan_t r;
    } mgr_obi_rsp_t;

    // Byte enables of the final word from the two low bits of the byte length.
    function automatic logic [3:0] len_to_last_be(input logic [1:0] len_lsb);
        logic [3:0] be;
        case (len_lsb)
            2'd1:    be = 4'b0001;
            2'd2:    be = 4'b0011;
            2'd3:    be = 4'b0111;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/obi_stream_wdma_fifo.sv
// Synchronous registered FIFO with occupancy count; one cycle from push to head, no bypass.
// Push is refused only when full with no pop in the same cycle, so full push+pop streams.
module obi_stream_wdma_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4,
    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW  = AddrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam logic [CntW-1:0] Full = CntW'(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [AddrW-1:0] r_wr_ptr;
    logic [AddrW-1:0] r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop   = pop_i && (r_count != '0);
    assign w_push  = push_i && ((r_count != Full) || w_pop);
    assign data_o  = r_mem[r_rd_ptr];
    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == Full);
    assign count_o = r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AddrW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AddrW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

// File: rtl/obi_stream_wdma.sv
// Stream-to-memory write DMA: buffers 32-bit stream words and writes them to consecutive word
// addresses over OBI; word reaches req one cycle after stream accept; stream stalls on full FIFO.
module obi_stream_wdma
    import user_pkg::*;
#(
    parameter int unsigned FifoDepth      = 4,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         testmode_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [31:0]  cmd_addr_i,
    input  logic [31:0]  cmd_len_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [31:0]  s_data_i,
    output mgr_obi_req_t mgr_req_o,
    input  mgr_obi_rsp_t mgr_rsp_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);

    localparam logic [1:0]  MaxOut = 2'(MaxOutstanding);
    localparam int unsigned CntW   = $clog2(FifoDepth) + 1;

    wdma_state_e r_state;
    wdma_state_e w_state_next;
    logic [31:0] r_addr;
    logic [30:0] r_nwords;
    logic [30:0] r_words_in;
    logic [30:0] r_words_out;
    logic [3:0]  r_last_be;
    logic [1:0]  r_outstanding;
    logic        r_err;
    logic        r_zero_done;

    logic            w_cmd_acc;
    logic [32:0]     w_len_ext;
    logic [30:0]     w_nwords;
    logic            w_push;
    logic            w_req;
    logic            w_hs;
    logic            w_rsp;
    logic            w_last_out;
    logic [31:0]     w_fifo_dat;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [CntW-1:0] w_fifo_count;
    logic            w_unused;

    assign w_cmd_acc  = cmd_valid_i && (r_state == WDMA_IDLE);
    assign w_len_ext  = {1'b0, cmd_len_i} + 33'd3;
    assign w_nwords   = w_len_ext[32:2];
    assign w_push     = s_valid_i && s_ready_o;
    assign w_req      = (r_state == WDMA_RUN) && !w_fifo_empty && (r_outstanding < MaxOut);
    assign w_hs       = w_req && mgr_rsp_i.gnt;
    // A response with nothing outstanding belongs to a request issued before a reset.
    assign w_rsp      = mgr_rsp_i.rvalid && (r_outstanding != 2'd0);
    assign w_last_out = (r_words_out == r_nwords - 31'd1);
    assign err_o      = r_err;
    assign w_unused   = ^{testmode_i, mgr_rsp_i.r.rdata, mgr_rsp_i.r.rid, w_fifo_count};

    obi_stream_wdma_fifo #(
        .Width (32),
        .Depth (FifoDepth)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (s_data_i),
        .pop_i   (w_hs),
        .data_o  (w_fifo_dat),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= WDMA_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WDMA_IDLE:  if (w_cmd_acc && (w_nwords != 31'd0)) w_state_next = WDMA_RUN;
            WDMA_RUN:   if (w_hs && w_last_out) w_state_next = WDMA_DRAIN;
            WDMA_DRAIN: if (r_outstanding == 2'd0) w_state_next = WDMA_IDLE;
            default:    w_state_next = WDMA_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = 1'b0;
        busy_o      = 1'b1;
        s_ready_o   = 1'b0;
        done_o      = r_zero_done;
        mgr_req_o   = '0;
        // Responses are always accepted; held low only while reset keeps the bus all-zero.
        mgr_req_o.rready = ~rst_i;
        case (r_state)
            WDMA_IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            WDMA_RUN: begin
                s_ready_o = !w_fifo_full && (r_words_in < r_nwords);
                if (w_req) begin
                    mgr_req_o.req     = 1'b1;
                    mgr_req_o.a.we    = 1'b1;
                    mgr_req_o.a.addr  = r_addr;
                    mgr_req_o.a.wdata = w_fifo_dat;
                    mgr_req_o.a.be    = w_last_out ? r_last_be : 4'b1111;
                    mgr_req_o.a.aid   = 1'b0;
                end
            end
            WDMA_DRAIN: done_o = (r_outstanding == 2'd0);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr        <= '0;
            r_nwords      <= '0;
            r_words_in    <= '0;
            r_words_out   <= '0;
            r_last_be     <= 4'b1111;
            r_outstanding <= '0;
            r_err         <= 1'b0;
            r_zero_done   <= 1'b0;
        end else begin
            r_zero_done <= w_cmd_acc && (w_nwords == 31'd0);
            if (w_cmd_acc) begin
                r_addr      <= {cmd_addr_i[31:2], 2'b00};
                r_nwords    <= w_nwords;
                r_last_be   <= len_to_last_be(cmd_len_i[1:0]);
                r_words_in  <= '0;
                r_words_out <= '0;
                r_err       <= 1'b0;
            end else begin
                if (w_push) r_words_in <= r_words_in + 31'd1;
                if (w_hs) begin
                    r_addr      <= r_addr + 32'd4;
                    r_words_out <= r_words_out + 31'd1;
                end
                if (w_rsp && mgr_rsp_i.r.err) r_err <= 1'b1;
            end
            case ({w_hs, w_rsp})
                2'b10:   r_outstanding <= r_outstanding + 2'd1;
                2'b01:   r_outstanding <= r_outstanding - 2'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_obi_stream_wdma.sv
// Directed bench for obi_stream_wdma: a stream source and an OBI subordinate with programmable
// grant/response latency run on the falling edge; each scenario task checks its own results.
module tb_obi_stream_wdma;
    import user_pkg::*;

    logic         clk;
    logic         rst;
    logic         testmode;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_addr;
    logic [31:0]  cmd_len;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    mgr_obi_req_t mgr_req;
    mgr_obi_rsp_t mgr_rsp;
    logic         busy;
    logic         done;
    logic         err;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        int          c;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] src_q[$];
    int          rq_due[$];

    int   cyc, done_cnt, req_cnt, gnt_wait, wait_cnt, r_lat, err_idx, rsp_cnt;
    int   out_m, max_out, stab_viol;
    bit   pend, sready_drop, inject, inject_err;
    logic err_at_done;
    logic [31:0] sv_addr, sv_data;
    logic [3:0]  sv_be;
    int   checks, errors;

    obi_stream_wdma #(
        .FifoDepth      (4),
        .MaxOutstanding (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .testmode_i  (testmode),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_addr_i  (cmd_addr),
        .cmd_len_i   (cmd_len),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .s_data_i    (s_data),
        .mgr_req_o   (mgr_req),
        .mgr_rsp_i   (mgr_rsp),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment: every falling edge it observes the DUT, then drives the inputs that the next
    // rising edge will sample, predicting which handshakes that edge completes.
    always @(negedge clk) begin
        cyc++;
        if (done) begin
            done_cnt++;
            err_at_done = err;
        end
        if (mgr_req.req) req_cnt++;
        if (rst) begin
            mgr_rsp.gnt = 1'b0; mgr_rsp.rvalid = 1'b0; mgr_rsp.r.err = 1'b0;
            s_valid = 1'b0; pend = 1'b0; wait_cnt = 0; out_m = 0;
        end else begin
            if (pend && (!mgr_req.req || mgr_req.a.addr !== sv_addr ||
                         mgr_req.a.wdata !== sv_data || mgr_req.a.be !== sv_be)) stab_viol++;
            if (mgr_req.req && wait_cnt >= gnt_wait) begin
                mgr_rsp.gnt = 1'b1; wait_cnt = 0;
            end else begin
                mgr_rsp.gnt = 1'b0;
                if (mgr_req.req) wait_cnt++;
            end
            pend = mgr_req.req && !mgr_rsp.gnt;
            sv_addr = mgr_req.a.addr; sv_data = mgr_req.a.wdata; sv_be = mgr_req.a.be;
            if (inject) begin
                mgr_rsp.rvalid = 1'b1; mgr_rsp.r.err = inject_err; inject = 1'b0;
            end else if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
                void'(rq_due.pop_front());
                rsp_cnt++;
                mgr_rsp.rvalid = 1'b1; mgr_rsp.r.err = (rsp_cnt == err_idx);
            end else begin
                mgr_rsp.rvalid = 1'b0; mgr_rsp.r.err = 1'b0;
            end
            if (mgr_rsp.rvalid && out_m > 0) out_m--;
            if (mgr_req.req && mgr_rsp.gnt) begin
                wr_q.push_back('{mgr_req.a.addr, mgr_req.a.wdata, mgr_req.a.be, cyc});
                rq_due.push_back(cyc + r_lat);
                out_m++;
            end
            if (out_m > max_out) max_out = out_m;
            if (src_q.size() > 0) begin
                s_valid = 1'b1; s_data = src_q[0];
                if (s_ready) void'(src_q.pop_front());
            end else begin
                s_valid = 1'b0;
            end
            if (busy && s_valid && !s_ready) sready_drop = 1'b1;
        end
    end

    task automatic issue_cmd(input logic [31:0] a, input logic [31:0] l);
        @(negedge clk);
        cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != start) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic prep(input int gw, input int rl, input int ei);
        wr_q.delete(); gnt_wait = gw; r_lat = rl; err_idx = ei; rsp_cnt = 0;
        max_out = 0; stab_viol = 0; sready_drop = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
        checks++; if ({busy, done, err, s_ready} !== 4'b0000) begin errors++; $display("FAIL rst_flags got busy/done/err/s_ready=%b want 0000", {busy, done, err, s_ready}); end
        checks++; if (mgr_req !== '0) begin errors++; $display("FAIL rst_mgr_req got %h want 0", mgr_req); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mgr_req.rready !== 1'b1 || mgr_req.req !== 1'b0) begin errors++; $display("FAIL idle_rready/req got %b/%b want 1/0", mgr_req.rready, mgr_req.req); end
    endtask

    task automatic test_basic();
        int d0; bit to;
        logic [31:0] ea [2] = '{32'h1000, 32'h1004};
        logic [31:0] ed [2] = '{32'hA, 32'hB};
        prep(0, 1, 0); d0 = done_cnt;
        src_q.push_back(32'hA); src_q.push_back(32'hB);
        issue_cmd(32'h1000, 32'd8);
        wait_done(d0, 50, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout no done_o within 50 cycles"); end
        checks++; if (wr_q.size() != 2) begin errors++; $display("FAIL basic_count got %0d writes want 2", wr_q.size()); end
        for (int i = 0; i < 2 && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i].a !== ea[i] || wr_q[i].d !== ed[i] || wr_q[i].be !== 4'b1111) begin
                errors++; $display("FAIL basic_wr%0d got %h/%h/%b want %h/%h/1111", i, wr_q[i].a, wr_q[i].d, wr_q[i].be, ea[i], ed[i]);
            end
        end
        checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", err_at_done); end
        repeat (3) @(negedge clk);
        checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_partial_last();
        int d0; bit to;
        prep(0, 1, 0); d0 = done_cnt;
        src_q.push_back(32'h11); src_q.push_back(32'h22);
        issue_cmd(32'h2003, 32'd5);
        wait_done(d0, 50, to);
        checks++; if (to || wr_q.size() != 2) begin errors++; $display("FAIL len5_count got %0d writes timeout=%b want 2", wr_q.size(), to); end
        else begin
            checks++; if (wr_q[0].a !== 32'h2000 || wr_q[0].be !== 4'b1111 || wr_q[0].d !== 32'h11) begin errors++; $display("FAIL len5_wr0 got %h/%b/%h want 2000/1111/11", wr_q[0].a, wr_q[0].be, wr_q[0].d); end
            checks++; if (wr_q[1].a !== 32'h2004 || wr_q[1].be !== 4'b0001 || wr_q[1].d !== 32'h22) begin errors++; $display("FAIL len5_wr1 got %h/%b/%h want 2004/0001/22", wr_q[1].a, wr_q[1].be, wr_q[1].d); end
        end
    endtask

    task automatic test_len0();
        int d0, r0;
        prep(0, 1, 0); d0 = done_cnt; r0 = req_cnt;
        issue_cmd(32'h7000, 32'd0);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len0_pulse got done/busy=%b/%b want 1/0", done, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL len0_after got done/busy/rdy=%b/%b/%b want 0/0/1", done, busy, cmd_ready); end
        repeat (3) @(negedge clk);
        checks++; if (req_cnt != r0 || wr_q.size() != 0 || done_cnt != d0 + 1) begin errors++; $display("FAIL len0_traffic got req_cycles=%0d writes=%0d dones=%0d want 0/0/1", req_cnt - r0, wr_q.size(), done_cnt - d0); end
    endtask

    task automatic test_stall();
        int d0; bit to; logic rdy_busy;
        prep(3, 2, 0); d0 = done_cnt;
        for (int i = 0; i < 8; i++) src_q.push_back(32'hC000 + i);
        issue_cmd(32'h3000, 32'd32);
        repeat (4) @(negedge clk);
        cmd_addr = 32'h9000; cmd_len = 32'd4; cmd_valid = 1'b1;
        rdy_busy = cmd_ready;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (rdy_busy !== 1'b0) begin errors++; $display("FAIL busy_cmd_ready got %b want 0", rdy_busy); end
        wait_done(d0, 400, to);
        checks++; if (to || wr_q.size() != 8) begin errors++; $display("FAIL stall_count got %0d writes timeout=%b want 8", wr_q.size(), to); end
        for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i].a !== 32'h3000 + 4 * i || wr_q[i].d !== 32'hC000 + i || wr_q[i].be !== 4'b1111) begin
                errors++; $display("FAIL stall_wr%0d got %h/%h/%b want %h/%h/1111", i, wr_q[i].a, wr_q[i].d, wr_q[i].be, 32'h3000 + 4 * i, 32'hC000 + i);
            end
        end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL stall_stable got %0d violations want 0", stab_viol); end
        checks++; if (max_out > 2) begin errors++; $display("FAIL stall_outstanding got %0d want <=2", max_out); end
        checks++; if (sready_drop !== 1'b1) begin errors++; $display("FAIL stall_sready_drop got %b want 1", sready_drop); end
        repeat (6) @(negedge clk);
        checks++; if (done_cnt != d0 + 1 || wr_q.size() != 8) begin errors++; $display("FAIL busy_cmd_ignored got dones=%0d writes=%0d want 1/8", done_cnt - d0, wr_q.size()); end
    endtask

    task automatic test_back_to_back();
        int d0; bit to;
        prep(0, 1, 0); d0 = done_cnt;
        for (int i = 0; i < 4; i++) src_q.push_back(32'hB0 + i);
        issue_cmd(32'h8000, 32'd16);
        wait_done(d0, 50, to);
        checks++; if (to || wr_q.size() != 4) begin errors++; $display("FAIL b2b_count got %0d writes timeout=%b want 4", wr_q.size(), to); end
        else begin
            checks++; if (wr_q[3].c - wr_q[0].c != 3) begin errors++; $display("FAIL b2b_rate got %0d cycles for 4 grants want 3", wr_q[3].c - wr_q[0].c); end
            checks++; if (wr_q[3].a !== 32'h800C || wr_q[3].d !== 32'hB3) begin errors++; $display("FAIL b2b_last got %h/%h want 800c/b3", wr_q[3].a, wr_q[3].d); end
        end
        prep(0, 6, 0); d0 = done_cnt;
        for (int i = 0; i < 4; i++) src_q.push_back(32'hD0 + i);
        issue_cmd(32'h8100, 32'd16);
        wait_done(d0, 80, to);
        checks++; if (to || max_out != 2) begin errors++; $display("FAIL max_outstanding got %0d timeout=%b want 2", max_out, to); end
    endtask

    task automatic test_err();
        int d0; bit to;
        prep(0, 1, 2); d0 = done_cnt;
        for (int i = 0; i < 3; i++) src_q.push_back(32'hE0 + i);
        issue_cmd(32'h4000, 32'd12);
        wait_done(d0, 50, to);
        checks++; if (to || err_at_done !== 1'b1) begin errors++; $display("FAIL err_at_done got %b timeout=%b want 1", err_at_done, to); end
        checks++; if (wr_q.size() != 3 || wr_q[wr_q.size()-1].a !== 32'h4008) begin errors++; $display("FAIL err_writes got %0d writes want 3 ending at 4008", wr_q.size()); end
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
        prep(0, 1, 0); d0 = done_cnt;
        src_q.push_back(32'hF0);
        issue_cmd(32'h4100, 32'd4);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear_on_accept got %b want 0", err); end
        wait_done(d0, 50, to);
        checks++; if (to || err_at_done !== 1'b0) begin errors++; $display("FAIL err_next_cmd got %b timeout=%b want 0", err_at_done, to); end
    endtask

    task automatic test_reset_midway();
        int d0; bit to;
        prep(0, 50, 0);
        src_q.push_back(32'h55);
        issue_cmd(32'h5000, 32'd8);
        for (int i = 0; i < 20 && wr_q.size() == 0; i++) @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1 || s_ready !== 1'b1 || wr_q.size() != 1) begin errors++; $display("FAIL midrst_pre got busy/s_ready/writes=%b/%b/%0d want 1/1/1", busy, s_ready, wr_q.size()); end
        #2 rst = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1 || {busy, done, err, s_ready} !== 4'b0000) begin errors++; $display("FAIL midrst_flags got rdy=%b busy/done/err/s_ready=%b want 1/0000", cmd_ready, {busy, done, err, s_ready}); end
        checks++; if (mgr_req !== '0) begin errors++; $display("FAIL midrst_mgr_req got %h want 0", mgr_req); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rq_due.delete(); src_q.delete();
        prep(0, 1, 0); d0 = done_cnt;
        issue_cmd(32'h6000, 32'd4);
        inject_err = 1'b1; inject = 1'b1;
        repeat (2) @(negedge clk);
        src_q.push_back(32'h66);
        wait_done(d0, 50, to);
        checks++; if (to) begin errors++; $display("FAIL midrst_new_cmd no done_o within 50 cycles"); end
        checks++; if (wr_q.size() != 1 || wr_q[0].a !== 32'h6000 || wr_q[0].d !== 32'h66 || wr_q[0].be !== 4'b1111) begin errors++; $display("FAIL midrst_write got %0d writes want one 6000/66/1111", wr_q.size()); end
        checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL midrst_stray_err got %b want 0", err_at_done); end
    endtask

    initial begin
        rst = 1'b1; testmode = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        s_valid = 1'b0; s_data = '0; mgr_rsp = '0;
        cyc = 0; done_cnt = 0; req_cnt = 0; gnt_wait = 0; wait_cnt = 0; r_lat = 1;
        err_idx = 0; rsp_cnt = 0; out_m = 0; max_out = 0; stab_viol = 0;
        pend = 1'b0; sready_drop = 1'b0; inject = 1'b0; inject_err = 1'b0; err_at_done = 1'b0;
        checks = 0; errors = 0;
        test_reset();
        test_basic();
        test_partial_last();
        test_len0();
        test_stall();
        test_back_to_back();
        test_err();
        test_reset_midway();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
